// File: rtl/mem_xfer_ctrl_pkg.sv
// Shared types and sizing for the memory transfer controller.
// Memory A holds 8 words that are consumed in pairs; each pair produces one word in memory B.
package mem_xfer_ctrl_pkg;

  localparam int DEPTH_A  = 8;
  localparam int DEPTH_B  = 4;
  localparam int ADDR_W_A = $clog2(DEPTH_A);
  localparam int ADDR_W_B = $clog2(DEPTH_B);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILL = 3'd1,
    ST_RD1  = 3'd2,
    ST_RD2  = 3'd3,
    ST_WRB  = 3'd4,
    ST_DONE = 3'd5
  } state_t;

endpackage

// File: rtl/mem_xfer_ctrl_if.sv
// Control bundle between the transfer controller and the external datapath.
// The slave modport is the controller's view; master is the datapath/bench side.
interface mem_xfer_ctrl_if;
  import mem_xfer_ctrl_pkg::*;

  logic                i_start;
  logic                i_cmp;
  logic                o_wea;
  logic                o_inca;
  logic [ADDR_W_A-1:0] o_addra;
  logic                o_ldr1;
  logic                o_ldr2;
  logic                o_web;
  logic                o_incb;
  logic [ADDR_W_B-1:0] o_addrb;
  logic                o_selsub;
  logic                o_busy;
  logic                o_done;

  modport slave (
    input  i_start, i_cmp,
    output o_wea, o_inca, o_addra, o_ldr1, o_ldr2,
           o_web, o_incb, o_addrb, o_selsub, o_busy, o_done
  );

  modport master (
    output i_start, i_cmp,
    input  o_wea, o_inca, o_addra, o_ldr1, o_ldr2,
           o_web, o_incb, o_addrb, o_selsub, o_busy, o_done
  );

endinterface

// File: rtl/mem_xfer_ctrl_mod_counter.sv
// Modulo-2^WIDTH address counter with enable.
// o_wrap flags the terminal value, so the next increment returns the count to zero.
module mod_counter #(
  parameter int WIDTH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count,
  output logic             o_wrap
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  // Depends only on the count, so the FSM can read it without a combinational loop.
  assign o_wrap  = (r_count == {WIDTH{1'b1}});
  assign o_count = r_count;

endmodule

// File: rtl/mem_xfer_ctrl.sv
// Transfer sequencer: fills memory A, then reads it pairwise and writes one result per pair to memory B.
// Datapath (memories, add/sub, compare, R1/R2) lives outside; only strobes and addresses come from here.
//
// state   | meaning
// IDLE    | waiting for start, all strobes low
// FILL    | write A[0..7], one word per cycle
// RD1     | load R1 from even A address
// RD2     | load R2 from odd A address
// WRB     | write B[k], SelSub follows Cmp
// DONE    | one-cycle completion pulse
module mem_xfer_ctrl
  import mem_xfer_ctrl_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  mem_xfer_ctrl_if.slave    bus
);

  state_t              r_state;
  state_t              w_next;
  logic                w_inc_a;
  logic                w_inc_b;
  logic                w_wrap_a;
  logic                w_wrap_b;
  logic [ADDR_W_A-1:0] w_addr_a;
  logic [ADDR_W_B-1:0] w_addr_b;

  mod_counter #(.WIDTH(ADDR_W_A)) u_cnt_a (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_inc_a),
    .o_count (w_addr_a),
    .o_wrap  (w_wrap_a)
  );

  mod_counter #(.WIDTH(ADDR_W_B)) u_cnt_b (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_inc   (w_inc_b),
    .o_count (w_addr_b),
    .o_wrap  (w_wrap_b)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_inc_a        = 1'b0;
    w_inc_b        = 1'b0;
    bus.o_wea      = 1'b0;
    bus.o_ldr1     = 1'b0;
    bus.o_ldr2     = 1'b0;
    bus.o_web      = 1'b0;
    bus.o_selsub   = 1'b0;
    bus.o_busy     = 1'b0;
    bus.o_done     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_start) w_next = ST_FILL;
      end
      ST_FILL: begin
        bus.o_wea  = 1'b1;
        bus.o_busy = 1'b1;
        w_inc_a    = 1'b1;
        if (w_wrap_a) w_next = ST_RD1;
      end
      ST_RD1: begin
        bus.o_ldr1 = 1'b1;
        bus.o_busy = 1'b1;
        w_inc_a    = 1'b1;
        w_next     = ST_RD2;
      end
      ST_RD2: begin
        bus.o_ldr2 = 1'b1;
        bus.o_busy = 1'b1;
        w_inc_a    = 1'b1;
        w_next     = ST_WRB;
      end
      ST_WRB: begin
        bus.o_web    = 1'b1;
        bus.o_selsub = bus.i_cmp;
        bus.o_busy   = 1'b1;
        w_inc_b      = 1'b1;
        w_next       = w_wrap_b ? ST_DONE : ST_RD1;
      end
      ST_DONE: begin
        bus.o_done = 1'b1;
        w_next     = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign bus.o_inca  = w_inc_a;
  assign bus.o_incb  = w_inc_b;
  assign bus.o_addra = w_addr_a;
  assign bus.o_addrb = w_addr_b;

endmodule

// File: tb/tb_mem_xfer_ctrl.sv
// Bench for mem_xfer_ctrl: a transfer-position model checked every cycle, plus directed
// scenarios with hand-computed expectations (single transfer, Cmp toggling, held Start, mid-transfer reset).
module tb_mem_xfer_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_vec  = 0;
  int   n_err  = 0;
  int   m_t    = 0;
  bit   chk_en = 1'b0;

  mem_xfer_ctrl_if bus();

  mem_xfer_ctrl dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // t = 0 idle, 1..8 fill, 9..20 pairs (read even, read odd, write B), 21 done.
  function automatic logic [14:0] model_vec(input int t, input logic cmp);
    logic       wea, inca, ldr1, ldr2, web, incb, selsub, busy, done;
    logic [2:0] aa;
    logic [1:0] ab;
    int         j, k, ph;
    wea = 0; inca = 0; ldr1 = 0; ldr2 = 0; web = 0; incb = 0;
    selsub = 0; busy = 0; done = 0; aa = '0; ab = '0;
    if (t >= 1 && t <= 8) begin
      wea = 1; inca = 1; busy = 1; aa = 3'(t - 1);
    end else if (t >= 9 && t <= 20) begin
      j = t - 9; k = j / 3; ph = j % 3;
      busy = 1; ab = 2'(k);
      if (ph == 0) begin
        ldr1 = 1; inca = 1; aa = 3'(2 * k);
      end else if (ph == 1) begin
        ldr2 = 1; inca = 1; aa = 3'(2 * k + 1);
      end else begin
        web = 1; incb = 1; selsub = cmp; aa = 3'((2 * k + 2) % 8);
      end
    end else if (t == 21) begin
      done = 1;
    end
    return {wea, inca, aa, ldr1, ldr2, web, incb, ab, selsub, busy, done};
  endfunction

  function automatic logic [14:0] dut_vec();
    return {bus.o_wea, bus.o_inca, bus.o_addra, bus.o_ldr1, bus.o_ldr2, bus.o_web,
            bus.o_incb, bus.o_addrb, bus.o_selsub, bus.o_busy, bus.o_done};
  endfunction

  task automatic chk(input string name, input int got, input int exp_v);
    n_vec++;
    if (got !== exp_v) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    if (rst)               m_t <= 0;
    else if (m_t == 0)     m_t <= bus.i_start ? 1 : 0;
    else if (m_t == 21)    m_t <= 0;
    else                   m_t <= m_t + 1;
  end

  always @(negedge clk) begin
    logic [14:0] e, g;
    if (chk_en) begin
      e = model_vec(m_t, bus.i_cmp);
      g = dut_vec();
      n_vec++;
      if (g !== e) begin
        n_err++;
        $display("FAIL outputs t=%0d got=%b exp=%b @%0t", m_t, g, e, $time);
      end
    end
  end

  initial begin
    int wea_cnt, done_cnt, done_at, web_cnt, fill_seq, ld1_seq, ld2_seq, b_seq, sel_seq;
    int busy_cnt, rise_cnt, r1, r2, r3;
    logic prev_busy;

    rst = 1'b1; bus.i_start = 1'b0; bus.i_cmp = 1'b0;
    step(); step();
    chk("reset_outputs", int'(dut_vec()), 0);
    bus.i_start = 1'b1;
    step();
    chk("reset_overrides_start", int'(bus.o_busy), 0);
    bus.i_start = 1'b0;
    rst = 1'b0; chk_en = 1'b1;
    step();

    // Single transfer, Cmp held low.
    wea_cnt = 0; done_cnt = 0; done_at = 0; web_cnt = 0;
    fill_seq = 0; ld1_seq = 0; ld2_seq = 0; b_seq = 0; sel_seq = 0; busy_cnt = 0;
    bus.i_start = 1'b1; step(); bus.i_start = 1'b0;
    for (int i = 1; i <= 24; i++) begin
      if (bus.o_wea)  begin wea_cnt++; fill_seq = (fill_seq << 3) | int'(bus.o_addra); end
      if (bus.o_ldr1) ld1_seq = (ld1_seq << 3) | int'(bus.o_addra);
      if (bus.o_ldr2) ld2_seq = (ld2_seq << 3) | int'(bus.o_addra);
      if (bus.o_web)  begin
        web_cnt++; b_seq = (b_seq << 2) | int'(bus.o_addrb);
        sel_seq = (sel_seq << 1) | int'(bus.o_selsub);
      end
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done) begin done_cnt++; done_at = i; end
      step();
    end
    chk("wea_count", wea_cnt, 8);
    chk("fill_addr_seq", fill_seq, 'o01234567);
    chk("ldr1_addr_seq", ld1_seq, 'o0246);
    chk("ldr2_addr_seq", ld2_seq, 'o1357);
    chk("web_count", web_cnt, 4);
    chk("addrb_seq", b_seq, 'h1B);
    chk("selsub_cmp0", sel_seq, 0);
    chk("busy_cycles", busy_cnt, 20);
    chk("done_count", done_cnt, 1);
    chk("done_cycle", done_at, 21);
    chk("addra_after_xfer", int'(bus.o_addra), 0);

    // Cmp toggles 1,0,1,0 in WRB cycles (11,14,17,20) and is random elsewhere.
    sel_seq = 0;
    bus.i_start = 1'b1; step(); bus.i_start = 1'b0;
    for (int i = 1; i <= 23; i++) begin
      if (i >= 11 && i <= 20 && ((i - 11) % 3) == 0) bus.i_cmp = (((i - 11) / 3) % 2) == 0;
      else bus.i_cmp = 1'($urandom_range(0, 1));
      #1;
      if (bus.o_web) sel_seq = (sel_seq << 1) | int'(bus.o_selsub);
      step();
    end
    bus.i_cmp = 1'b0;
    chk("selsub_toggle", sel_seq, 'b1010);

    // Start held high: transfers repeat every 22 cycles.
    rise_cnt = 0; r1 = 0; r2 = 0; r3 = 0; prev_busy = 1'b0;
    bus.i_start = 1'b1;
    step();
    for (int i = 1; i <= 60; i++) begin
      if (bus.o_busy && !prev_busy) begin
        rise_cnt++;
        if (rise_cnt == 1) r1 = i; else if (rise_cnt == 2) r2 = i; else r3 = i;
      end
      prev_busy = bus.o_busy;
      step();
    end
    bus.i_start = 1'b0;
    chk("held_start_rises", rise_cnt, 3);
    chk("held_start_first", r1, 1);
    chk("held_start_gap1", r2 - r1, 22);
    chk("held_start_gap2", r3 - r2, 22);
    for (int i = 0; i < 30; i++) step();

    // Reset during the second RD2 cycle (t = 13).
    bus.i_start = 1'b1; step(); bus.i_start = 1'b0;
    for (int i = 1; i <= 12; i++) step();
    chk("pre_reset_ldr2", int'(bus.o_ldr2), 1);
    rst = 1'b1; step(); rst = 1'b0;
    chk("abort_busy", int'(bus.o_busy), 0);
    chk("abort_addra", int'(bus.o_addra), 0);
    chk("abort_addrb", int'(bus.o_addrb), 0);
    done_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (bus.o_done) done_cnt++;
      step();
    end
    chk("abort_no_done", done_cnt, 0);
    busy_cnt = 0; done_at = 0;
    bus.i_start = 1'b1; step(); bus.i_start = 1'b0;
    chk("restart_addra", int'(bus.o_addra), 0);
    for (int i = 1; i <= 24; i++) begin
      if (bus.o_busy) busy_cnt++;
      if (bus.o_done) done_at = i;
      step();
    end
    chk("restart_busy_cycles", busy_cnt, 20);
    chk("restart_done_cycle", done_at, 21);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
